// File: rtl/fft_stage_sequencer.sv
// Control sequencer for an in-place radix-2 DIT FFT: bit-reversed load, NL2 butterfly
// stages on one shared butterfly, then a handshaked stream of N/2 output-bin addresses.
module fft_stage_sequencer #(
    parameter int unsigned N      = 32,
    parameter int unsigned NL2    = 5,
    parameter int unsigned STW    = 4,
    parameter int unsigned BF_LAT = 0
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    output logic           busy_o,
    output logic           done_o,
    output logic           load_en_o,
    output logic [NL2-1:0] load_src_o,
    output logic [NL2-1:0] load_dst_o,
    output logic           bf_en_o,
    output logic [NL2-1:0] bf_ind1_o,
    output logic [NL2-1:0] bf_ind2_o,
    output logic [NL2-2:0] bf_tind_o,
    output logic [STW-1:0] stage_o,
    output logic           rd_valid_o,
    input  logic           rd_ready_i,
    output logic [NL2-2:0] rd_addr_o,
    output logic           rd_last_o
);

    localparam int unsigned HW   = NL2 - 1;
    localparam int unsigned HALF = N / 2;
    localparam int unsigned DW   = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;

    localparam logic [NL2-1:0] K_LAST      = NL2'(N - 1);
    localparam logic [NL2-1:0] C_LAST      = NL2'(HALF - 1);
    localparam logic [STW-1:0] STAGE_LAST  = STW'(NL2);
    localparam logic [DW-1:0]  DRAIN_LAST  = DW'((BF_LAT > 0) ? (BF_LAT - 1) : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_BFLY,
        S_DRAIN,
        S_READ,
        S_FIN
    } state_e;

    state_e         state_q, state_d;
    logic [NL2-1:0] cnt_q, cnt_d;
    logic [STW-1:0] stage_q, stage_d;
    logic [DW-1:0]  drain_q, drain_d;
    logic           stage_adv;

    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           load_en_q, load_en_d;
    logic [NL2-1:0] load_src_q, load_src_d;
    logic [NL2-1:0] load_dst_q, load_dst_d;
    logic           bf_en_q, bf_en_d;
    logic [NL2-1:0] ind1_q, ind1_d;
    logic [NL2-1:0] ind2_q, ind2_d;
    logic [HW-1:0]  tind_q, tind_d;
    logic           rd_valid_q, rd_valid_d;
    logic [HW-1:0]  rd_addr_q, rd_addr_d;
    logic           rd_last_q, rd_last_d;

    logic [STW-1:0] pos_d;
    logic [NL2-1:0] mask_d;
    logic [NL2-1:0] cext_d;

    function automatic logic [NL2-1:0] bitrev(input logic [NL2-1:0] k);
        logic [NL2-1:0] r;
        for (int i = 0; i < NL2; i++) begin
            r[i] = k[NL2-1-i];
        end
        return r;
    endfunction

    // Next state, counters, and next values of every registered output
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stage_d   = stage_q;
        drain_d   = drain_q;
        stage_adv = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    stage_d = '0;
                end
            end
            S_LOAD: begin
                if (cnt_q == K_LAST) begin
                    state_d = S_BFLY;
                    cnt_d   = '0;
                    stage_d = STW'(1);
                end else begin
                    cnt_d = cnt_q + NL2'(1);
                end
            end
            S_BFLY: begin
                if (cnt_q == C_LAST) begin
                    cnt_d = '0;
                    if (BF_LAT > 0) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end else begin
                        stage_adv = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + NL2'(1);
                end
            end
            S_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    stage_adv = 1'b1;
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            S_READ: begin
                if (rd_ready_i) begin
                    if (cnt_q == C_LAST) begin
                        state_d = S_FIN;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + NL2'(1);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                stage_d = '0;
            end
        endcase

        // Stage wrap: the last stage hands over to the output-address stream
        if (stage_adv) begin
            cnt_d = '0;
            if (stage_q == STAGE_LAST) begin
                state_d = S_READ;
                stage_d = '0;
            end else begin
                state_d = S_BFLY;
                stage_d = stage_q + STW'(1);
            end
        end

        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_FIN);
        load_en_d  = (state_d == S_LOAD);
        load_src_d = load_en_d ? cnt_d : '0;
        load_dst_d = load_en_d ? bitrev(cnt_d) : '0;
        bf_en_d    = (state_d == S_BFLY);
        rd_valid_d = (state_d == S_READ);
        rd_addr_d  = rd_valid_d ? cnt_d[HW-1:0] : '0;
        rd_last_d  = rd_valid_d && (cnt_d == C_LAST);

        // Butterfly operand pair: insert a 0 bit at position pos into cnt
        pos_d  = stage_d - STW'(1);
        mask_d = ({NL2{1'b1}} >> pos_d) << pos_d;
        cext_d = {1'b0, cnt_d[HW-1:0]};
        ind1_d = '0;
        ind2_d = '0;
        tind_d = '0;
        if (bf_en_d) begin
            ind1_d = ((cext_d & mask_d) << 1) | (cext_d & ~mask_d);
            ind2_d = ind1_d | (NL2'(1) << pos_d);
            tind_d = cnt_d[HW-1:0] << (STAGE_LAST - stage_d);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            stage_q    <= '0;
            drain_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            load_en_q  <= 1'b0;
            load_src_q <= '0;
            load_dst_q <= '0;
            bf_en_q    <= 1'b0;
            ind1_q     <= '0;
            ind2_q     <= '0;
            tind_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stage_q    <= stage_d;
            drain_q    <= drain_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            load_en_q  <= load_en_d;
            load_src_q <= load_src_d;
            load_dst_q <= load_dst_d;
            bf_en_q    <= bf_en_d;
            ind1_q     <= ind1_d;
            ind2_q     <= ind2_d;
            tind_q     <= tind_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            rd_last_q  <= rd_last_d;
        end
    end

    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign load_en_o  = load_en_q;
    assign load_src_o = load_src_q;
    assign load_dst_o = load_dst_q;
    assign bf_en_o    = bf_en_q;
    assign bf_ind1_o  = ind1_q;
    assign bf_ind2_o  = ind2_q;
    assign bf_tind_o  = tind_q;
    assign stage_o    = stage_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_addr_o  = rd_addr_q;
    assign rd_last_o  = rd_last_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench for fft_stage_sequencer: one instance with BF_LAT=0, one with BF_LAT=2,
// observed through a shared selector.
module tb_fft_stage_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start0, start2, rd_ready;
    bit   sel;

    logic       busy0, done0, load_en0, bf_en0, rd_valid0, rd_last0;
    logic [4:0] load_src0, load_dst0, ind1_0, ind2_0;
    logic [3:0] tind0, stage0, rd_addr0;
    logic       busy2, done2, load_en2, bf_en2, rd_valid2, rd_last2;
    logic [4:0] load_src2, load_dst2, ind1_2, ind2_2;
    logic [3:0] tind2, stage2, rd_addr2;

    fft_stage_sequencer #(.N(32), .NL2(5), .STW(4), .BF_LAT(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start0), .busy_o(busy0), .done_o(done0),
        .load_en_o(load_en0), .load_src_o(load_src0), .load_dst_o(load_dst0),
        .bf_en_o(bf_en0), .bf_ind1_o(ind1_0), .bf_ind2_o(ind2_0), .bf_tind_o(tind0),
        .stage_o(stage0), .rd_valid_o(rd_valid0), .rd_ready_i(rd_ready),
        .rd_addr_o(rd_addr0), .rd_last_o(rd_last0)
    );

    fft_stage_sequencer #(.N(32), .NL2(5), .STW(4), .BF_LAT(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .busy_o(busy2), .done_o(done2),
        .load_en_o(load_en2), .load_src_o(load_src2), .load_dst_o(load_dst2),
        .bf_en_o(bf_en2), .bf_ind1_o(ind1_2), .bf_ind2_o(ind2_2), .bf_tind_o(tind2),
        .stage_o(stage2), .rd_valid_o(rd_valid2), .rd_ready_i(rd_ready),
        .rd_addr_o(rd_addr2), .rd_last_o(rd_last2)
    );

    logic       busy, done, load_en, bf_en, rd_valid, rd_last;
    logic [4:0] load_src, load_dst, ind1, ind2;
    logic [3:0] tind, stage, rd_addr;

    assign busy     = sel ? busy2     : busy0;
    assign done     = sel ? done2     : done0;
    assign load_en  = sel ? load_en2  : load_en0;
    assign bf_en    = sel ? bf_en2    : bf_en0;
    assign rd_valid = sel ? rd_valid2 : rd_valid0;
    assign rd_last  = sel ? rd_last2  : rd_last0;
    assign load_src = sel ? load_src2 : load_src0;
    assign load_dst = sel ? load_dst2 : load_dst0;
    assign ind1     = sel ? ind1_2    : ind1_0;
    assign ind2     = sel ? ind2_2    : ind2_0;
    assign tind     = sel ? tind2     : tind0;
    assign stage    = sel ? stage2    : stage0;
    assign rd_addr  = sel ? rd_addr2  : rd_addr0;

    int errors   = 0;
    int checks   = 0;
    int tick_cnt = 0;
    int done_cnt = 0;

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        tick_cnt++;
        check("exclusive_enables", 32'((32'(load_en) + 32'(bf_en) + 32'(rd_valid)) <= 1), 32'd1);
    endtask

    function automatic int bitrev_m(input int k);
        int r = 0;
        for (int i = 0; i < 5; i++) begin
            r = (r << 1) | (k & 1);
            k = k >> 1;
        end
        return r;
    endfunction

    function automatic int ind1_m(input int c, input int s);
        int pos = s - 1;
        return ((c >> pos) << (pos + 1)) | (c & ((1 << pos) - 1));
    endfunction

    // One full transform on the selected instance, starting from IDLE
    task automatic run_transform(input int lat, input bit toggle_rdy);
        int  t0, base_done, e, ph;
        int  seen [32];
        int  hits;
        int  first5 [5] = '{0, 16, 8, 24, 4};
        logic [3:0] pat = 4'b1001;
        logic rdy;
        base_done = done_cnt;
        t0 = tick_cnt;
        if (sel) start2 = 1'b1; else start0 = 1'b1;
        tick();
        start0 = 1'b0;
        start2 = 1'b0;
        for (int k = 0; k < 32; k++) begin
            check("load_en", 32'(load_en), 32'd1);
            check("load_src", 32'(load_src), 32'(k));
            check("load_dst", 32'(load_dst), 32'(bitrev_m(k)));
            if (k < 5) check("load_dst_hand", 32'(load_dst), 32'(first5[k]));
            if (k == 31) check("load_dst_last", 32'(load_dst), 32'd31);
            tick();
        end
        for (int s = 1; s <= 5; s++) begin
            for (int i = 0; i < 32; i++) seen[i] = 0;
            for (int c = 0; c < 16; c++) begin
                check("bf_en", 32'(bf_en), 32'd1);
                check("stage", 32'(stage), 32'(s));
                check("ind1", 32'(ind1), 32'(ind1_m(c, s)));
                check("ind2", 32'(ind2), 32'(ind1_m(c, s) + (1 << (s - 1))));
                check("tind", 32'(tind), 32'((c << (5 - s)) & 15));
                if (s == 1 && c == 3) begin
                    check("t2_s1c3_ind1", 32'(ind1), 32'd6);
                    check("t2_s1c3_ind2", 32'(ind2), 32'd7);
                    check("t2_s1c3_tind", 32'(tind), 32'd0);
                end
                if (s == 5 && c == 3) begin
                    check("t2_s5c3_ind1", 32'(ind1), 32'd3);
                    check("t2_s5c3_ind2", 32'(ind2), 32'd19);
                    check("t2_s5c3_tind", 32'(tind), 32'd3);
                end
                if (s == 3 && c == 5) begin
                    check("t2_s3c5_ind1", 32'(ind1), 32'd9);
                    check("t2_s3c5_ind2", 32'(ind2), 32'd13);
                    check("t2_s3c5_tind", 32'(tind), 32'd4);
                end
                seen[ind1]++;
                seen[ind2]++;
                tick();
            end
            hits = 0;
            for (int i = 0; i < 32; i++) if (seen[i] == 1) hits++;
            check("stage_cover", 32'(hits), 32'd32);
            for (int d = 0; d < lat; d++) begin
                check("drain_bf_en", 32'(bf_en), 32'd0);
                check("drain_stage", 32'(stage), 32'(s));
                check("drain_busy", 32'(busy), 32'd1);
                tick();
            end
        end
        e = 0;
        ph = 0;
        for (int g = 0; g < 200; g++) begin
            check("rd_valid", 32'(rd_valid), 32'd1);
            check("rd_addr", 32'(rd_addr), 32'(e));
            check("rd_last", 32'(rd_last), 32'(e == 15));
            check("rd_stage", 32'(stage), 32'd0);
            rdy = toggle_rdy ? pat[3 - (ph % 4)] : 1'b1;
            rd_ready = rdy;
            ph++;
            tick();
            if (rdy) begin
                if (e == 15) break;
                e++;
            end
        end
        rd_ready = 1'b1;
        check("fin_done", 32'(done), 32'd1);
        check("fin_busy", 32'(busy), 32'd1);
        check("fin_rd_valid", 32'(rd_valid), 32'd0);
        if (!toggle_rdy) check("latency", 32'(tick_cnt - t0 + 1), 32'(130 + 5 * lat));
        tick();
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("done_pulses", 32'(done_cnt - base_done), 32'd1);
    endtask

    initial begin
        int t1, t2, g, base;
        rst = 1'b1;
        start0 = 1'b0;
        start2 = 1'b0;
        rd_ready = 1'b1;
        sel = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_load_en", 32'(load_en), 32'd0);
        check("rst_bf_en", 32'(bf_en), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_stage", 32'(stage), 32'd0);
        check("rst_rd_addr", 32'(rd_addr), 32'd0);
        check("rst_busy2", 32'(busy2), 32'd0);
        rst = 1'b0;
        tick();

        // BF_LAT=0 full run, then BF_LAT=2, then back-pressured read
        sel = 1'b0;
        run_transform(0, 1'b0);
        sel = 1'b1;
        run_transform(2, 1'b0);
        sel = 1'b0;
        run_transform(0, 1'b1);

        // Reset mid-stage-3 aborts at once
        base = done_cnt;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        repeat (32 + 16 + 16 + 5) tick();
        check("abort_stage_pre", 32'(stage), 32'd3);
        check("abort_bf_en_pre", 32'(bf_en), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bf_en", 32'(bf_en), 32'd0);
        check("abort_load_en", 32'(load_en), 32'd0);
        check("abort_rd_valid", 32'(rd_valid), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_stage", 32'(stage), 32'd0);
        repeat (3) begin
            tick();
            check("abort_stays_idle", 32'(busy), 32'd0);
        end
        check("abort_no_done", 32'(done_cnt - base), 32'd0);
        run_transform(0, 1'b0);

        // start held high: back-to-back transforms, start ignored while busy
        start0 = 1'b1;
        g = 0;
        while (!done && g < 400) begin tick(); g++; end
        t1 = tick_cnt;
        tick();
        g = 0;
        while (!done && g < 400) begin tick(); g++; end
        t2 = tick_cnt;
        check("held_period1", 32'(t2 - t1), 32'd130);
        tick();
        g = 0;
        while (!done && g < 400) begin tick(); g++; end
        check("held_period2", 32'(tick_cnt - t2), 32'd130);
        start0 = 1'b0;
        g = 0;
        while (busy && g < 400) begin tick(); g++; end
        check("held_release_idle", 32'(busy), 32'd0);
        tick();
        check("held_stays_idle", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
